// File: rtl/pc_sn_seq_ctrl.sv
// Sequential popcount: one 15:4 sorting-network slice walks an operand.
// Ports: clk, rst_n, clear, in_valid/in_ready/in_data, out_valid/out_ready/out_count, busy.

module pc_sn_15_4 (
  input  logic [14:0] bits,
  output logic [3:0]  count
);

  // Odd-even transposition sort pushes all ones to the low end,
  // turning the input into a thermometer code of its popcount.
  function automatic logic [3:0] sn_count(input logic [14:0] b);
    logic [14:0] s;
    logic        hi;
    logic        lo;
    logic [3:0]  c;
    s = b;
    for (int st = 0; st < 15; st++) begin
      for (int i = st % 2; i < 14; i += 2) begin
        hi     = s[i] | s[i+1];
        lo     = s[i] & s[i+1];
        s[i]   = hi;
        s[i+1] = lo;
      end
    end
    c = 4'd0;
    for (int k = 0; k < 15; k++) begin
      if (s[k]) c = 4'(k + 1);
    end
    return c;
  endfunction

  assign count = sn_count(bits);

endmodule

module pc_sn_seq_ctrl #(
  parameter  int SLICES = 4,
  localparam int IN_W   = 15 * SLICES,
  localparam int CW     = $clog2(IN_W + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   out_count,
  output logic            busy
);

  localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   acc;
  logic [IN_W-1:0] opnd;
  logic [14:0]     slice;
  logic [3:0]      cnt;
  logic [CW-1:0]   cnt_ext;
  logic            last;
  logic            accept;

  assign slice   = opnd[15*idx +: 15];
  assign cnt_ext = {{(CW-4){1'b0}}, cnt};
  assign last    = (idx == IW'(SLICES - 1));

  assign in_ready = (state == IDLE) |
                    ((state == DONE) & out_ready & ~clear);
  assign accept   = in_valid & in_ready & ~clear;

  assign out_count = acc;

  pc_sn_15_4 u_slice (
    .bits  (slice),
    .count (cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      opnd      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      // Also covers DONE: result taken and next operand loaded together.
      opnd      <= in_data;
      idx       <= '0;
      acc       <= '0;
      state     <= RUN;
      out_valid <= 1'b0;
      busy      <= 1'b1;
    end else begin
      unique case (state)
        IDLE: ;
        RUN: begin
          acc <= acc + cnt_ext;
          if (last) begin
            idx       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sn_seq_ctrl.sv
// Bench for pc_sn_seq_ctrl at SLICES=4.
// Scoreboard queue of expected counts, popped by a handshake monitor.

module tb_pc_sn_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [59:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_count;
  logic        busy;

  int          n_cmp;
  int          n_err;
  int          n_hs;
  int          cyc;
  int          acc_cyc;
  logic [5:0]  exp_q[$];

  pc_sn_seq_ctrl #(.SLICES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every result handshake is checked against the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_hs++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got %0d expected none", out_count);
      end else begin
        chk("result", int'(out_count), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input logic [59:0] d, input bit push,
                      input logic [5:0] e);
    bit ok;
    ok = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    if (push) exp_q.push_back(e);
    for (int i = 0; i < 30; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
      acc_cyc = cyc;
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (out_valid) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
    if (lat < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no out_valid expected one");
    end
  endtask

  int lat;
  int bc;
  int t1;
  int hs0;

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    n_hs      = 0;
    acc_cyc   = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_count", int'(out_count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All ones: latency and busy window.
    send(60'hFFF_FFFF_FFFF_FFFF, 1'b1, 6'd60);
    wait_done(lat, bc);
    chk("ones_latency", lat, 4);
    chk("ones_busy_cycles", bc, 4);

    send(60'h0, 1'b1, 6'd0);
    wait_done(lat, bc);
    send(60'h000_0000_0000_7FFF, 1'b1, 6'd15);
    wait_done(lat, bc);
    chk("lowslice_latency", lat, 4);
    send(60'h800_0000_0000_0001, 1'b1, 6'd2);
    wait_done(lat, bc);
    send(60'h555_5555_5555_5555, 1'b1, 6'd30);
    wait_done(lat, bc);

    // Back-to-back; second operand offered during RUN must be ignored.
    @(posedge clk);
    #1;
    send(60'hFFF_FFFF_FFFF_FFFF, 1'b1, 6'd60);
    in_data  = 60'h555_5555_5555_5555;
    in_valid = 1'b1;
    exp_q.push_back(6'd30);
    wait_done(lat, bc);
    chk("b2b_in_ready_done", int'(in_ready), 1);
    t1 = cyc;
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    wait_done(lat, bc);
    chk("b2b_spacing", cyc - t1, 5);

    // Stall in DONE with offered operand that must be ignored.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(60'hFFF_FFFF_FFFF_FFFF, 1'b1, 6'd60);
    wait_done(lat, bc);
    in_data  = 60'h3;
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_count", int'(out_count), 60);
      chk("stall_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    hs0       = n_hs;
    repeat (3) @(negedge clk);
    chk("stall_handshakes", n_hs - hs0, 1);
    chk("stall_idle_valid", int'(out_valid), 0);
    chk("stall_idle_busy", int'(busy), 0);
    chk("stall_idle_ready", int'(in_ready), 1);

    // Clear at RUN idx 2 drops the first operand.
    @(posedge clk);
    #1;
    send(60'hFFF_FFFF_FFFF_FFFF, 1'b0, 6'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clear_busy", int'(busy), 0);
    send(60'h3, 1'b1, 6'd2);
    wait_done(lat, bc);
    chk("clear_next_latency", lat, 4);

    // Reset at RUN idx 1.
    @(posedge clk);
    #1;
    send(60'hFFF_FFFF_FFFF_FFFF, 1'b0, 6'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_count", int'(out_count), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hs0   = n_hs;
    repeat (8) @(negedge clk);
    chk("post_rst_no_result", n_hs - hs0, 0);
    @(posedge clk);
    #1;
    send(60'h800_0000_0000_0001, 1'b1, 6'd2);
    wait_done(lat, bc);
    repeat (2) @(negedge clk);

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
